// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Runs the inhibit / request-to-send handshake, shifts one byte plus odd
// parity and stop bit out on device-generated clock edges, then checks the ACK.
// Optional build macro: PS2_TX_GLITCH_FILTER_EN adds a 4-sample stability
// filter on the synchronised PS2C level before falling-edge detection.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int EDGE_TIMEOUT   = 375000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_drive_low,
    output logic       ps2d_drive_low,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > EDGE_TIMEOUT) ? INHIBIT_CYCLES : EDGE_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(EDGE_TIMEOUT - 1);
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_NOACK = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_CLK_REL, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_FAIL
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       bit_q;
    logic [9:0]       frame_q;
    logic             ps2c_drv_q;
    logic             ps2d_drv_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic [1:0]       err_code_q;

    logic ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q, ps2c_prev_q;
    logic ps2c_lvl;
    logic ps2c_fall;
    logic tmo_hit;

    // Two-flop synchronisers on both pins; idle level is high so they reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2c_s1_q <= 1'b1;
            ps2c_s2_q <= 1'b1;
            ps2d_s1_q <= 1'b1;
            ps2d_s2_q <= 1'b1;
        end else begin
            ps2c_s1_q <= ps2c_in;
            ps2c_s2_q <= ps2c_s1_q;
            ps2d_s1_q <= ps2d_in;
            ps2d_s2_q <= ps2d_s1_q;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic [2:0] ps2c_hist_q;
    logic       ps2c_filt_q;

    // Filtered clock level moves only once four consecutive samples agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2c_hist_q <= 3'b111;
            ps2c_filt_q <= 1'b1;
        end else begin
            ps2c_hist_q <= {ps2c_hist_q[1:0], ps2c_s2_q};
            if (&{ps2c_hist_q, ps2c_s2_q}) begin
                ps2c_filt_q <= 1'b1;
            end else if (~|{ps2c_hist_q, ps2c_s2_q}) begin
                ps2c_filt_q <= 1'b0;
            end
        end
    end

    assign ps2c_lvl = ps2c_filt_q;
`else
    assign ps2c_lvl = ps2c_s2_q;
`endif

    // Previous clock level for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2c_prev_q <= 1'b1;
        end else begin
            ps2c_prev_q <= ps2c_lvl;
        end
    end

    assign ps2c_fall = ps2c_prev_q & ~ps2c_lvl;
    assign tmo_hit   = (cnt_q == TMO_LAST) && !ps2c_fall;

    // Transmit FSM; all outputs are registered here. The edge timer keeps running
    // across CLK_REL -> SEND so the wait for the first device edge is one window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            frame_q    <= '0;
            ps2c_drv_q <= 1'b0;
            ps2d_drv_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ps2c_drv_q <= 1'b0;
                    ps2d_drv_q <= 1'b0;
                    if (tx_start) begin
                        frame_q    <= {1'b1, ~^tx_data, tx_data};
                        err_code_q <= ERR_NONE;
                        busy_q     <= 1'b1;
                        ps2c_drv_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        cnt_q      <= '0;
                        ps2d_drv_q <= 1'b1;
                        state_q    <= S_RTS;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RTS: begin
                    ps2c_drv_q <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= S_CLK_REL;
                end
                S_CLK_REL: begin
                    bit_q   <= '0;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (ps2c_fall) begin
                        ps2d_drv_q <= ~frame_q[bit_q];
                        cnt_q      <= '0;
                        bit_q      <= (bit_q == 4'd10) ? 4'd10 : bit_q + 4'd1;
                        if (bit_q == 4'd9) begin
                            state_q <= S_ACK;
                        end
                    end else if (tmo_hit) begin
                        ps2c_drv_q <= 1'b0;
                        ps2d_drv_q <= 1'b0;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TMO;
                        state_q    <= S_FAIL;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_ACK: begin
                    if (ps2c_fall) begin
                        cnt_q <= '0;
                        if (!ps2d_s2_q) begin
                            state_q <= S_WAIT_IDLE;
                        end else begin
                            ps2c_drv_q <= 1'b0;
                            ps2d_drv_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_NOACK;
                            state_q    <= S_FAIL;
                        end
                    end else if (tmo_hit) begin
                        ps2c_drv_q <= 1'b0;
                        ps2d_drv_q <= 1'b0;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TMO;
                        state_q    <= S_FAIL;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (ps2c_lvl && ps2d_s2_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (ps2c_fall) begin
                        cnt_q <= '0;
                    end else if (tmo_hit) begin
                        ps2c_drv_q <= 1'b0;
                        ps2d_drv_q <= 1'b0;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TMO;
                        state_q    <= S_FAIL;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_FAIL: begin
                    ps2c_drv_q <= 1'b0;
                    ps2d_drv_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ps2c_drive_low = ps2c_drv_q;
    assign ps2d_drive_low = ps2d_drv_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign err_code       = err_code_q;

endmodule
